dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 33 +++
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between a data-memory initiator and dmem_responder.
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata/req_be    : store data and byte-lane enables
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : load data and reject flag
// Modports: master (initiator side), slave (responder side).
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder with programmable wait states.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, then the storage
// access happens on the edge entering RESP; the response is held until
// rsp_ready.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (storage is not cleared)
//   bus  : dmem_responder_if.slave request/response bus
// Parameters:
//   DEPTH       : number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES : wait states before every response (0..15)
// Configuration:
//   DMEM_RESP_ERR_CHECK_EN : when defined, misaligned or out-of-range
//   requests are rejected with rsp_err=1; otherwise the index wraps modulo
//   DEPTH and rsp_err is constant 0.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic [31:0] mem_q [DEPTH];

    logic          enter_resp;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx;
    logic          acc_err;

    // With zero wait states RESP is entered on the accepting edge itself, so
    // the access must see the live request rather than the not-yet-captured one.
    assign acc_we    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
    assign acc_be    = (state_q == ST_IDLE) ? bus.req_be    : be_q;
    assign acc_idx   = acc_addr[AW+1:2];

`ifdef DMEM_RESP_ERR_CHECK_EN
    assign acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
`else
    logic unused_addr;
    assign unused_addr = ^{acc_addr[31:AW+2], acc_addr[1:0]};
    assign acc_err     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            rdata_d = (!acc_we && !acc_err) ? mem_q[acc_idx] : '0;
            err_d   = acc_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset; the rst term keeps a request arriving while reset
    // is held from writing through the zero-wait path.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && acc_we && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Table-driven bench for dmem_responder: one instance with WAIT_CYCLES=2 runs
// the vector table and the multi-cycle corner sequences, a second instance
// with WAIT_CYCLES=0 covers the zero-wait path. Expected responses go into a
// queue when a request is driven and are popped when the response appears.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if ifa ();
    dmem_responder_if ifb ();

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t tbl[$];

`ifdef DMEM_RESP_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] be, logic [31:0] rd, logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = rd; v.exp_err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        ifa.req_we    = v.we;
        ifa.req_addr  = v.addr;
        ifa.req_wdata = v.wdata;
        ifa.req_be    = v.be;
        ifa.req_valid = 1'b1;
    endtask

    // Counts edges from acceptance until rsp_valid is seen (sampled at negedge).
    task automatic wait_rsp_a(input string tag, input int exp_lat);
        int lat = 1;
        while (!ifa.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic collect_a(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, ifa.rsp_rdata, e.rdata);
            check({tag, "_err"}, {31'd0, ifa.rsp_err}, {31'd0, e.err});
        end
    endtask

    task automatic handshake_a(input string tag);
        ifa.rsp_ready = 1'b1;
        @(negedge clk);
        ifa.rsp_ready = 1'b0;
        check({tag, "_valid_after_hs"}, {31'd0, ifa.rsp_valid}, 32'd0);
        check({tag, "_rdata_after_hs"}, ifa.rsp_rdata, 32'd0);
    endtask

    // Full transaction on the WAIT_CYCLES=2 instance; called at a negedge in IDLE.
    task automatic txn_a(input string tag, input vec_t v);
        drive_a(v);
        check({tag, "_req_ready"}, {31'd0, ifa.req_ready}, 32'd1);
        sb.push_back('{v.exp_rdata, v.exp_err});
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        wait_rsp_a(tag, 3);
        collect_a(tag);
        handshake_a(tag);
    endtask

    task automatic txn_b(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd);
        int lat = 1;
        ifb.req_we = we; ifb.req_addr = addr; ifb.req_wdata = wdata; ifb.req_be = 4'hF;
        ifb.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.req_valid = 1'b0;
        while (!ifb.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd1);
        check({tag, "_rdata"}, ifb.rsp_rdata, exp_rd);
        check({tag, "_err"}, {31'd0, ifb.rsp_err}, 32'd0);
        ifb.rsp_ready = 1'b1;
        @(negedge clk);
        ifb.rsp_ready = 1'b0;
        check({tag, "_valid_after_hs"}, {31'd0, ifb.rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        logic [31:0] hold_rd;

        tbl.push_back(mk(1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0));
        tbl.push_back(mk(1'b1, 32'h10,  32'h00001234, 4'h3, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h10,  32'h0,        4'hF, 32'hDEAD1234, 1'b0));
        tbl.push_back(mk(1'b1, 32'h14,  32'hCAFEF00D, 4'hF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h14,  32'h11223344, 4'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h14,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0));
        tbl.push_back(mk(1'b1, 32'h18,  32'hFFFFFFFF, 4'hF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h18,  32'h00AB0000, 4'h4, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h18,  32'h0,        4'h0, 32'hFFABFFFF, 1'b0));
        tbl.push_back(mk(1'b1, 32'h20,  32'h00000000, 4'hF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0,   32'h55555555, 4'hF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h13,  32'h0,        4'hF, ERR_EN ? 32'h0 : 32'hDEAD1234, ERR_EN));
        tbl.push_back(mk(1'b1, 32'h400, 32'h99999999, 4'hF, 32'h0, ERR_EN));
        tbl.push_back(mk(1'b0, 32'h0,   32'h0,        4'hF, ERR_EN ? 32'h55555555 : 32'h99999999, 1'b0));

        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0;
        ifa.req_wdata = '0;   ifa.req_be = '0;   ifa.rsp_ready = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0;
        ifb.req_wdata = '0;   ifb.req_be = '0;   ifb.rsp_ready = 1'b0;

        // Reset state
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", ifa.rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'd0, ifa.rsp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, ifa.req_ready}, 32'd1);

        foreach (tbl[i]) begin
            txn_a($sformatf("vec%0d", i), tbl[i]);
        end

        // Backpressure: response held 5 cycles while a new request is offered.
        drive_a(mk(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD1234, 1'b0));
        sb.push_back('{32'hDEAD1234, 1'b0});
        @(posedge clk);
        @(negedge clk);
        drive_a(mk(1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0));
        wait_rsp_a("bp", 3);
        collect_a("bp");
        hold_rd = 32'hDEAD1234;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", {31'd0, ifa.rsp_valid}, 32'd1);
            check("bp_hold_rdata", ifa.rsp_rdata, hold_rd);
            check("bp_hold_req_ready", {31'd0, ifa.req_ready}, 32'd0);
            @(negedge clk);
        end
        drive_a(mk(1'b0, 32'h18, 32'h0, 4'hF, 32'hFFABFFFF, 1'b0));
        ifa.rsp_ready = 1'b1;
        @(negedge clk);
        ifa.rsp_ready = 1'b0;
        check("bp_no_accept_at_hs", {31'd0, ifa.req_ready}, 32'd1);
        check("bp_valid_after_hs",  {31'd0, ifa.rsp_valid}, 32'd0);
        sb.push_back('{32'hFFABFFFF, 1'b0});
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        wait_rsp_a("bp_next", 3);
        collect_a("bp_next");
        handshake_a("bp_next");
        txn_a("bp_ignored_store", mk(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD1234, 1'b0));

        // Request withdrawn before any edge sees it.
        drive_a(mk(1'b1, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0));
        #2 ifa.req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("wd_req_ready", {31'd0, ifa.req_ready}, 32'd1);
            check("wd_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
        end
        txn_a("wd_load", mk(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD1234, 1'b0));

        // Reset during WAIT aborts the store.
        drive_a(mk(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        check("rw_in_wait", {31'd0, ifa.req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rw_async_valid", {31'd0, ifa.rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rw_valid_after", {31'd0, ifa.rsp_valid}, 32'd0);
        check("rw_ready_after", {31'd0, ifa.req_ready}, 32'd1);
        txn_a("rw_load", mk(1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0));

        // Reset during RESP drops the response immediately.
        drive_a(mk(1'b0, 32'h18, 32'h0, 4'hF, 32'h0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rr_in_resp", {31'd0, ifa.rsp_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check("rr_async_valid", {31'd0, ifa.rsp_valid}, 32'd0);
        check("rr_async_rdata", ifa.rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rr_ready_after", {31'd0, ifa.req_ready}, 32'd1);

        // Zero-wait instance.
        txn_b("w0_store", 1'b1, 32'h0, 32'h12345678, 32'h0);
        txn_b("w0_load",  1'b0, 32'h0, 32'h0,        32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
